// File: rtl/sift_kp_pkg.sv
// Shared constants, types and word packing for the keypoint output stream.
// No logic of its own; used by keypoint_stream_out.
// Optional build macro referenced here: KP_STREAM_CHKSUM_EN (adds the CHK state).
package sift_kp_pkg;

    localparam int ADDR_W = 11;
    localparam int KP_W   = 19;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int MAX_KP = 2000;

    localparam logic [3:0]  HDR_TAG  = 4'hC;
    localparam logic [15:0] END_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_W0,
        ST_W1,
        ST_ENDW
`ifdef KP_STREAM_CHKSUM_EN
        , ST_CHK
`endif
    } state_t;

    // Memory word layout: row in the upper 9 bits, col in the lower 10.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } kp_t;

    // Counts above the memory depth are treated as a full memory.
    function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] c);
        return (c > ADDR_W'(MAX_KP)) ? ADDR_W'(MAX_KP) : c;
    endfunction

    // Word emitted in each state; states without a fixed word yield 0.
    function automatic logic [15:0] pack_word(input state_t st, input logic lst,
                                              input logic [ADDR_W-1:0] cnt, input kp_t kp);
        logic [15:0] w;
        case (st)
            ST_HDR:  w = {HDR_TAG, lst, cnt};
            ST_W0:   w = {7'd0, kp.row};
            ST_W1:   w = {6'd0, kp.col};
            ST_ENDW: w = END_WORD;
            default: w = 16'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/keypoint_stream_out.sv
// Walks keypoint lists 1 and 2 and emits a framed 16-bit stream (HDR, row/col pairs, END).
// Latency: first word valid the cycle after start; one word per cycle while out_ready is high.
// Backpressure: out_valid && !out_ready holds state, word and addresses; no out_ready comb path.
// Build macro KP_STREAM_CHKSUM_EN inserts a checksum word before END_WORD.
module keypoint_stream_out
    import sift_kp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] kp1_count,
    input  logic [ADDR_W-1:0] kp2_count,
    output logic [ADDR_W-1:0] kp1_addr,
    input  logic [KP_W-1:0]   kp1_dout,
    output logic [ADDR_W-1:0] kp2_addr,
    input  logic [KP_W-1:0]   kp2_dout,
    output logic              out_valid,
    output logic [15:0]       out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

`ifdef KP_STREAM_CHKSUM_EN
    localparam state_t ST_TAIL = ST_CHK;
`else
    localparam state_t ST_TAIL = ST_ENDW;
`endif

    state_t            state_q;
    logic              list_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cnt1_q;
    logic [ADDR_W-1:0] cnt2_q;
    kp_t               kp_q;
    logic              done_q;

    logic [ADDR_W-1:0] cur_cnt;
    kp_t               cur_dout;
    logic              accept;
    logic              rd_active;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       word_w;

    assign cur_cnt   = list_q ? cnt2_q : cnt1_q;
    assign cur_dout  = list_q ? kp_t'(kp2_dout) : kp_t'(kp1_dout);
    assign out_valid = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign accept    = out_valid && out_ready;

    // The active list is addressed by idx; saturating keeps a full list inside the memory.
    assign rd_active = (state_q == ST_HDR) || (state_q == ST_W0) || (state_q == ST_W1);
    assign rd_addr   = (idx_q >= ADDR_W'(MAX_KP)) ? ADDR_W'(MAX_KP - 1) : idx_q;
    assign kp1_addr  = (rd_active && !list_q) ? rd_addr : '0;
    assign kp2_addr  = (rd_active &&  list_q) ? rd_addr : '0;

`ifdef KP_STREAM_CHKSUM_EN
    logic [15:0] acc_q;

    // Running modulo-2^16 sum of every accepted header and data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            acc_q <= '0;
        end else if (accept && rd_active) begin
            acc_q <= acc_q + word_w;
        end
    end

    // Output word decode from registered state only, with the checksum slot.
    always_comb begin
        word_w   = pack_word(state_q, list_q, cur_cnt, kp_q);
        out_data = (state_q == ST_CHK) ? acc_q : word_w;
    end
`else
    // Output word decode from registered state only.
    always_comb begin
        word_w   = pack_word(state_q, list_q, cur_cnt, kp_q);
        out_data = word_w;
    end
`endif

    // Stream sequencer: headers, row/col pairs per keypoint, tail words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            list_q  <= 1'b0;
            idx_q   <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            kp_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt1_q  <= clamp_count(kp1_count);
                        cnt2_q  <= clamp_count(kp2_count);
                        idx_q   <= '0;
                        list_q  <= 1'b0;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        if (cur_cnt != '0) begin
                            kp_q    <= cur_dout;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_W0;
                        end else if (!list_q) begin
                            list_q  <= 1'b1;
                            idx_q   <= '0;
                            state_q <= ST_HDR;
                        end else begin
                            state_q <= ST_TAIL;
                        end
                    end
                end
                ST_W0: begin
                    if (out_ready) begin
                        state_q <= ST_W1;
                    end
                end
                ST_W1: begin
                    if (out_ready) begin
                        if (idx_q < cur_cnt) begin
                            kp_q    <= cur_dout;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_W0;
                        end else if (!list_q) begin
                            list_q  <= 1'b1;
                            idx_q   <= '0;
                            state_q <= ST_HDR;
                        end else begin
                            state_q <= ST_TAIL;
                        end
                    end
                end
`ifdef KP_STREAM_CHKSUM_EN
                ST_CHK: begin
                    if (out_ready) begin
                        state_q <= ST_ENDW;
                    end
                end
`endif
                ST_ENDW: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_stream_out.sv
// Randomised bench for keypoint_stream_out: reference stream built from memory contents and counts.
// Drives on negedge, samples on negedge (outputs settle after posedge).
// Build macro KP_STREAM_CHKSUM_EN changes the expected stream to include the checksum word.
module tb_keypoint_stream_out;

    localparam int DEPTH = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] kp1_count;
    logic [10:0] kp2_count;
    logic [10:0] kp1_addr;
    logic [10:0] kp2_addr;
    logic [18:0] kp1_dout;
    logic [18:0] kp2_dout;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [18:0] mem1 [DEPTH];
    logic [18:0] mem2 [DEPTH];

    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    logic [15:0] basic_ref [$];

    int total = 0;
    int bad   = 0;
    int peak1;
    int peak2;
    int n_exp;

    keypoint_stream_out dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kp1_count (kp1_count),
        .kp2_count (kp2_count),
        .kp1_addr  (kp1_addr),
        .kp1_dout  (kp1_dout),
        .kp2_addr  (kp2_addr),
        .kp2_dout  (kp2_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read keypoint memories.
    always @(posedge clk) begin
        kp1_dout <= (kp1_addr < 11'd2000) ? mem1[kp1_addr] : 19'd0;
        kp2_dout <= (kp2_addr < 11'd2000) ? mem2[kp2_addr] : 19'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference stream from the framing rules, using plain arithmetic on memory contents.
    task automatic build_expected(input int c1, input int c2);
        int e1, e2, sum;
        e1  = (c1 > DEPTH) ? DEPTH : c1;
        e2  = (c2 > DEPTH) ? DEPTH : c2;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(16'(32'hC000 + e1));
        for (int i = 0; i < e1; i++) begin
            exp_q.push_back(16'(int'(mem1[i]) / 1024));
            exp_q.push_back(16'(int'(mem1[i]) % 1024));
        end
        exp_q.push_back(16'(32'hC800 + e2));
        for (int i = 0; i < e2; i++) begin
            exp_q.push_back(16'(int'(mem2[i]) / 1024));
            exp_q.push_back(16'(int'(mem2[i]) % 1024));
        end
        foreach (exp_q[i]) sum = sum + int'(exp_q[i]);
`ifdef KP_STREAM_CHKSUM_EN
        exp_q.push_back(16'(sum % 65536));
`endif
        exp_q.push_back(16'hFFFF);
        n_exp = exp_q.size();
    endtask

    // rmode: 0 always ready, 1 alternating, 2 random. abort_after>0 resets after that many words.
    task automatic run_stream(input int c1, input int c2, input int rmode,
                              input int abort_after, input bit mid_start);
        int          cyc, nacc, early_done;
        bit          ended, finished, hold;
        logic [15:0] hold_dat, w;
        build_expected(c1, c2);
        got_q.delete();
        peak1 = 0; peak2 = 0; early_done = 0;
        cyc = 0; nacc = 0; ended = 0; finished = 0; hold = 0; hold_dat = '0;
        @(negedge clk);
        kp1_count = 11'(c1);
        kp2_count = 11'(c2);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        while (!finished && cyc < 12000) begin
            if (int'(kp1_addr) > peak1) peak1 = int'(kp1_addr);
            if (int'(kp2_addr) > peak2) peak2 = int'(kp2_addr);
            if (done) early_done++;
            start = mid_start && busy && ($urandom_range(0, 7) == 0);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(hold_dat));
            end
            hold = 0;
            if (out_valid && out_ready) begin
                nacc++;
                got_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check_eq("word_count", 32'(nacc), 32'(n_exp));
                end else begin
                    w = exp_q.pop_front();
                    check_eq("word", 32'(out_data), 32'(w));
                    if (exp_q.size() == 0) ended = 1;
                end
                if (abort_after != 0 && nacc == abort_after) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst   = 1'b0;
                    start = 1'b0;
                    check_eq("abort_valid", 32'(out_valid), 32'd0);
                    check_eq("abort_busy", 32'(busy), 32'd0);
                    check_eq("abort_done", 32'(done), 32'd0);
                    check_eq("abort_addr1", 32'(kp1_addr), 32'd0);
                    check_eq("abort_addr2", 32'(kp2_addr), 32'd0);
                    finished = 1;
                    break;
                end
            end else if (out_valid) begin
                hold     = 1;
                hold_dat = out_data;
            end
            @(negedge clk);
            cyc++;
            if (ended) begin
                start = 1'b0;
                check_eq("done_pulse", 32'(done), 32'd1);
                check_eq("busy_at_done", 32'(busy), 32'd0);
                check_eq("valid_at_done", 32'(out_valid), 32'd0);
                check_eq("stray_done", 32'(early_done), 32'd0);
                if (rmode == 0) check_eq("stream_cycles", 32'(cyc), 32'(n_exp));
                finished = 1;
            end
        end
        start = 1'b0;
        if (!finished) check_eq("timeout", 32'(cyc), 32'd0);
        check_eq("addr_in_range", 32'(peak1 < DEPTH && peak2 < DEPTH), 32'd1);
    endtask

    task automatic load_basic();
        mem1[0] = {9'd5, 10'd17};
        mem1[1] = {9'd479, 10'd639};
        mem2[0] = 19'd0;
    endtask

    task automatic check_basic_literal(input string tag);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(basic_ref.size()));
        foreach (basic_ref[i]) begin
            if (i < got_q.size()) check_eq(tag, 32'(got_q[i]), 32'(basic_ref[i]));
        end
    endtask

    initial begin
        basic_ref = '{16'hC002, 16'h0005, 16'h0011, 16'h01DF, 16'h027F, 16'hC801, 16'h0000, 16'h0000,
`ifdef KP_STREAM_CHKSUM_EN
                      16'h8C77,
`endif
                      16'hFFFF};
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
        end
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        kp1_count = '0; kp2_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_addr1", 32'(kp1_addr), 32'd0);
        check_eq("rst_addr2", 32'(kp2_addr), 32'd0);

        load_basic();
        run_stream(2, 1, 0, 0, 1'b0);
        check_basic_literal("basic");

        run_stream(0, 0, 0, 0, 1'b0);
        check_eq("empty_peak1", 32'(peak1), 32'd0);
        check_eq("empty_peak2", 32'(peak2), 32'd0);

        run_stream(2, 1, 1, 0, 1'b0);
        check_basic_literal("bp_alt");

        run_stream(2, 1, 2, 0, 1'b1);
        check_basic_literal("bp_rand_midstart");

        for (int t = 0; t < 6; t++) begin
            run_stream(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 2, 0, 1'b1);
        end

        run_stream(2047, 0, 0, 0, 1'b0);
        check_eq("clamp_hdr", 32'(got_q[0]), 32'h0000C7D0);
        check_eq("clamp_peak1", 32'(peak1), 32'd1999);
        check_eq("clamp_peak2", 32'(peak2), 32'd0);

        load_basic();
        run_stream(2, 1, 0, 3, 1'b0);
        run_stream(2, 1, 0, 0, 1'b0);
        check_basic_literal("after_abort");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
